data_memory_bank: RTL and testbench

Parametrised successor to the processor's 16-word data memory. It is a single-port RAM with:
- configurable data width and depth
- byte-lane write enables
- registered (1-cycle) reads with a valid strobe
- selectable read-during-write mode
- a hardware init sequencer that loads a fixed preload table after every reset

It sits between the datapath's ALU address output and the writeback mux. The datapath stalls while Busy is high.

---
 rtl/data_memory_bank_if.sv | 26 ++
 rtl/data_memory_bank.sv | 115 +++++++++++
 tb/tb_data_memory_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_bank_if.sv
// Request/response bundle between the datapath and data_memory_bank.
// The datapath drives requests (master); the memory bank returns registered data and status (slave).
interface data_memory_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic                  MemWrite;
  logic                  MemRead;
  logic [ADDR_W-1:0]     Addr;
  logic [DATA_W-1:0]     In;
  logic [DATA_W/8-1:0]   ByteEn;
  logic [DATA_W-1:0]     Out;
  logic                  OutValid;
  logic                  Busy;
  logic                  Fault;

  modport master (
    output MemWrite, MemRead, Addr, In, ByteEn,
    input  Out, OutValid, Busy, Fault
  );

  modport slave (
    input  MemWrite, MemRead, Addr, In, ByteEn,
    output Out, OutValid, Busy, Fault
  );
endinterface

// File: rtl/data_memory_bank.sv
// Single-port data RAM with byte-lane writes, 1-cycle registered reads and a post-reset
// preload sequencer that holds Busy until the preload table has been written.
module data_memory_bank #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WRITE_FIRST = 0
) (
  input logic                Clk,
  input logic                Reset,
  data_memory_bank_if.slave  bus
);

  localparam int unsigned NUM_LANES = DATA_W / 8;

  typedef enum logic {StInit, StReady} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   out_q;
  logic                out_valid_q;
  logic                fault_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] idx);
    logic [15:0] v;
    case (int'(idx))
      1:       v = 16'h0001;
      2:       v = 16'h0080;
      3:       v = 16'h0092;
      default: v = 16'h0000;
    endcase
    return DATA_W'(v);
  endfunction

  always_comb begin
    // Extra bit so DEPTH == 2**ADDR_W compares correctly.
    in_range    = {1'b0, bus.Addr} < (ADDR_W + 1)'(DEPTH);
    old_word    = in_range ? mem[bus.Addr] : '0;
    merged_word = old_word;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (bus.ByteEn[i]) merged_word[8*i +: 8] = bus.In[8*i +: 8];
    end

    mem_we    = 1'b0;
    mem_waddr = bus.Addr;
    mem_wdata = merged_word;
    if (!Reset) begin
      if (state_q == StInit) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = preload(cnt_q);
      end else if (bus.MemWrite && in_range && (|bus.ByteEn)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        StReady: begin
          if (bus.MemRead) begin
            out_valid_q <= 1'b1;
            if (!in_range) begin
              out_q <= '0;
            end else if ((WRITE_FIRST != 0) && bus.MemWrite) begin
              out_q <= merged_word;
            end else begin
              out_q <= old_word;
            end
          end
          fault_q <= !in_range && (bus.MemRead || bus.MemWrite);
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.Out      = out_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Fault    = fault_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: three builds (old-data, new-data, 10-word) driven in lockstep
// and compared each cycle against a word-level reference model.
module tb_data_memory_bank;

  localparam int NDUT = 3;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  data_memory_bank_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
  data_memory_bank_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();
  data_memory_bank_if #(.DATA_W(16), .ADDR_W(4)) bus2 ();

  data_memory_bank #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .WRITE_FIRST(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0)
  );
  data_memory_bank #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .WRITE_FIRST(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1)
  );
  data_memory_bank #(.DATA_W(16), .ADDR_W(4), .DEPTH(10), .WRITE_FIRST(0)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2)
  );

  int          depth_m  [NDUT] = '{16, 16, 10};
  bit          wf_m     [NDUT] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] mem_m    [NDUT][16];
  int          init_left[NDUT];
  logic [15:0] exp_out  [NDUT];
  bit          exp_valid[NDUT];
  bit          exp_fault[NDUT];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] preload_m(int a);
    if (a == 1) return 16'h0001;
    if (a == 2) return 16'h0080;
    if (a == 3) return 16'h0092;
    return 16'h0000;
  endfunction

  task automatic check(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_dut(int k, logic [15:0] out, logic v, logic f, logic b);
    check("busy", k, {15'b0, b}, {15'b0, init_left[k] > 0});
    check("valid", k, {15'b0, v}, {15'b0, exp_valid[k]});
    check("fault", k, {15'b0, f}, {15'b0, exp_fault[k]});
    check("out", k, out, exp_out[k]);
  endtask

  // Reference behaviour of one clock edge for every build.
  task automatic model_edge(bit rst, bit rd, bit wr, logic [3:0] a, logic [15:0] d,
                            logic [1:0] be);
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        init_left[k] = depth_m[k];
        exp_out[k]   = 16'h0000;
        exp_valid[k] = 1'b0;
        exp_fault[k] = 1'b0;
        for (int w = 0; w < 16; w++) mem_m[k][w] = (w < depth_m[k]) ? preload_m(w) : 16'h0000;
      end else if (init_left[k] > 0) begin
        init_left[k]--;
        exp_valid[k] = 1'b0;
        exp_fault[k] = 1'b0;
      end else begin
        bit          inr;
        logic [15:0] old_w;
        logic [15:0] new_w;
        inr   = int'(a) < depth_m[k];
        old_w = mem_m[k][a];
        new_w = old_w;
        for (int i = 0; i < 2; i++) begin
          if (be[i]) new_w = (new_w & ~(16'h00FF << (8 * i))) | (d & (16'h00FF << (8 * i)));
        end
        if (wr && inr) mem_m[k][a] = new_w;
        exp_valid[k] = rd;
        if (rd) exp_out[k] = !inr ? 16'h0000 : ((wf_m[k] && wr) ? new_w : old_w);
        exp_fault[k] = !inr && (rd || wr);
      end
    end
  endtask

  task automatic step(bit rst, bit rd, bit wr, logic [3:0] a, logic [15:0] d, logic [1:0] be);
    Reset         = rst;
    bus0.MemRead  = rd; bus0.MemWrite = wr; bus0.Addr = a; bus0.In = d; bus0.ByteEn = be;
    bus1.MemRead  = rd; bus1.MemWrite = wr; bus1.Addr = a; bus1.In = d; bus1.ByteEn = be;
    bus2.MemRead  = rd; bus2.MemWrite = wr; bus2.Addr = a; bus2.In = d; bus2.ByteEn = be;
    @(posedge Clk);
    model_edge(rst, rd, wr, a, d, be);
    #1;
    check_dut(0, bus0.Out, bus0.OutValid, bus0.Fault, bus0.Busy);
    check_dut(1, bus1.Out, bus1.OutValid, bus1.Fault, bus1.Busy);
    check_dut(2, bus2.Out, bus2.OutValid, bus2.Fault, bus2.Busy);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
  endtask

  task automatic rd(logic [3:0] a);
    step(1'b0, 1'b1, 1'b0, a, 16'h0000, 2'b00);
  endtask

  task automatic wr(logic [3:0] a, logic [15:0] d, logic [1:0] be);
    step(1'b0, 1'b0, 1'b1, a, d, be);
  endtask

  initial begin
    // Reset held two cycles, then a read of address 3 lands mid-INIT and must be dropped.
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
    idle(3);
    rd(4'd3);
    idle(14);

    // Preload contents, back-to-back reads.
    rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd3); rd(4'd15);
    idle(1);

    // Byte-lane writes, including an all-lanes-off write.
    wr(4'd5, 16'hABCD, 2'b01); rd(4'd5);
    wr(4'd5, 16'h1234, 2'b10); rd(4'd5);
    wr(4'd5, 16'hFFFF, 2'b00); rd(4'd5);

    // Collision at address 2, then a plain re-read.
    step(1'b0, 1'b1, 1'b1, 4'd2, 16'h5555, 2'b11);
    rd(4'd2);
    idle(1);

    // Out-of-range for the 10-word build.
    wr(4'd12, 16'hFFFF, 2'b11); rd(4'd12);
    for (int a = 0; a < 10; a++) rd(4'(a));
    idle(1);

    // Overwrite address 1, then reset again mid-INIT at cnt = 7.
    wr(4'd1, 16'hBEEF, 2'b11); rd(4'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
    idle(7);
    step(1'b1, 1'b1, 1'b0, 4'd1, 16'h0000, 2'b00);
    idle(16);
    rd(4'd1);
    idle(1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
